// File: rtl/mesh_job_driver.sv
// mesh_job_driver: host-side initiator for the mesh top. Streams weights into
// the mesh preload port, launches one job per input vector, waits a fixed
// compute window and hands the captured result back on a valid/ready stream.
module mesh_job_driver #(
    parameter int DW          = 8,
    parameter int ROWS        = 1,
    parameter int COLS        = 1,
    parameter int ROW_W       = 1,
    parameter int COL_W       = 2,
    parameter int ACC_W       = 16,
    parameter int N_WEIGHTS   = 4,
    parameter int COMPUTE_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reload,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DW-1:0]           w_data,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic [COLS*DW-1:0]      x_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ROWS*ACC_W-1:0]   res_data,
    output logic                    preload_valid,
    output logic [ROW_W+COL_W-1:0]  preload_addr,
    output logic [DW-1:0]           preload_data,
    output logic                    start,
    output logic [COLS*DW-1:0]      x_vector_flat,
    input  logic [ROWS*ACC_W-1:0]   result_flat,
    output logic                    busy
);

    localparam int AW = ROW_W + COL_W;
    localparam int CW = $clog2(COMPUTE_CYC + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           wcnt_q, wcnt_d;
    logic [CW-1:0]           ccnt_q, ccnt_d;
    logic                    pl_valid_q, pl_valid_d;
    logic [AW-1:0]           pl_addr_q, pl_addr_d;
    logic [DW-1:0]           pl_data_q, pl_data_d;
    logic [COLS*DW-1:0]      xvec_q, xvec_d;
    logic                    res_valid_q, res_valid_d;
    logic [ROWS*ACC_W-1:0]   res_data_q, res_data_d;

    // State-decoded handshake/status outputs; forced low while reset is held.
    always_comb begin
        w_ready = !rst && (state_q == S_LOAD);
        x_ready = !rst && (state_q == S_IDLE) && !reload;
        start   = !rst && (state_q == S_START);
        busy    = !rst && (state_q != S_IDLE);
    end

    assign preload_valid = pl_valid_q;
    assign preload_addr  = pl_addr_q;
    assign preload_data  = pl_data_q;
    assign x_vector_flat = xvec_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;

    // Next-state logic for the job sequencer and its registered outputs.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ccnt_d      = ccnt_q;
        pl_valid_d  = 1'b0;
        pl_addr_d   = pl_addr_q;
        pl_data_d   = pl_data_q;
        xvec_d      = xvec_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            S_LOAD: begin
                if (w_valid && w_ready) begin
                    pl_valid_d = 1'b1;
                    pl_addr_d  = wcnt_q;
                    pl_data_d  = w_data;
                    if (wcnt_q == AW'(N_WEIGHTS - 1)) begin
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (reload) begin
                    wcnt_d  = '0;
                    state_d = S_LOAD;
                end else if (x_valid) begin
                    xvec_d  = x_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                ccnt_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                ccnt_d = ccnt_q + 1'b1;
                if (ccnt_q == CW'(COMPUTE_CYC - 1)) begin
                    res_data_d  = result_flat;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and output registers; reset drops any job and invalidates weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            wcnt_q      <= '0;
            ccnt_q      <= '0;
            pl_valid_q  <= 1'b0;
            pl_addr_q   <= '0;
            pl_data_q   <= '0;
            xvec_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ccnt_q      <= ccnt_d;
            pl_valid_q  <= pl_valid_d;
            pl_addr_q   <= pl_addr_d;
            pl_data_q   <= pl_data_d;
            xvec_q      <= xvec_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: doc/mesh_job_driver.md
Name: mesh_job_driver

Overview:
- Initiator side of the mesh top's preload/start/vector interface.
- Accepts a weight stream from the host and issues per-address preload writes.
- Accepts input vectors from the host, latches each onto x_vector_flat and pulses start.
- Waits a fixed compute window, captures result_flat and returns it on a valid/ready result stream. Sits between the host fabric and the mesh top; the integration wrapper drives the mesh's rst_n from ~rst.

Parameters:
DW, 8, weight/element width
ROWS, 1, mesh rows (result lanes)
COLS, 1, mesh columns (vector lanes)
ROW_W, 1, row address bits
COL_W, 2, column address bits
ACC_W, 16, result lane width
N_WEIGHTS, 4, preload writes per weight load (1..2**(ROW_W+COL_W))
COMPUTE_CYC, 8, cycles from start pulse to result capture (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
reload  in  1  single-cycle request to reload weights, honoured in IDLE only
w_valid  in  1  host weight valid
w_ready  out  1  weight accept
w_data  in  DW  signed weight
x_valid  in  1  host vector valid
x_ready  out  1  vector accept
x_data  in  COLS*DW  input vector
res_valid  out  1  result valid
res_ready  in  1  result accept
res_data  out  ROWS*ACC_W  captured result
preload_valid  out  1  mesh preload strobe
preload_addr  out  ROW_W+COL_W  mesh preload address
preload_data  out  DW  mesh preload data
start  out  1  mesh start pulse
x_vector_flat  out  COLS*DW  vector to mesh, held stable
result_flat  in  ROWS*ACC_W  mesh result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; state LOAD; weight counter wcnt=0; compute counter ccnt=0. Weights are considered invalid after any reset, including mid-job; any in-flight job is dropped and no result is produced.
- States and transitions:
  - LOAD: w_ready=1. On each w_valid&&w_ready, the next cycle drives preload_valid=1, preload_addr=wcnt, preload_data=w_data (registered outputs, 1-cycle latency); then wcnt++. The handshake with wcnt==N_WEIGHTS-1 clears wcnt and moves to IDLE. No w_valid means the state holds and preload_valid=0.
  - IDLE: x_ready=1, w_ready=0. reload=1 clears wcnt and moves to LOAD; reload wins over a same-cycle x_valid, and x_ready is 0 that cycle. On x_valid&&x_ready, latch x_data into x_vector_flat and move to START.
  - START: start=1 for exactly this one cycle; clear ccnt; move to RUN.
  - RUN: ccnt++ each cycle. In the cycle ccnt==COMPUTE_CYC-1, register result_flat into res_data, set res_valid=1 and move to DONE.
  - DONE: hold res_valid and res_data stable until res_ready. The handshake cycle clears res_valid and moves to IDLE.
- Latency: x handshake at cycle T gives start at T+1, result capture at the edge ending cycle T+1+COMPUTE_CYC, and res_valid high at T+2+COMPUTE_CYC.
- x_vector_flat changes only on an x handshake and stays stable through START, RUN and DONE.
- preload_valid is never high outside the cycle after a LOAD handshake. preload_addr and preload_data hold their last values when it is low.
- Ignored inputs: reload outside IDLE; w_valid outside LOAD; x_valid outside IDLE.
- res_ready high before res_valid has no effect.
- Back-to-back jobs: the minimum initiation interval is COMPUTE_CYC+3 cycles with res_ready held high.

Test Plan:
1. Reset, then weights 3,-2,7,-1, one per cycle with w_valid held → preload_valid high 4 consecutive cycles, addr 0..3, data 3,-2,7,-1; w_ready drops after the 4th; busy then 0.
2. After load, x_data=5 at cycle T, stub mesh drives result_flat=16'h1234 → start high at T+1 only; res_valid at T+10 with res_data=16'h1234 (COMPUTE_CYC=8).
3. res_ready held low 5 cycles after res_valid while result_flat changes → res_data stays 16'h1234; x_ready=0; on res_ready, IDLE next cycle.
4. reload and x_valid asserted in the same IDLE cycle → no x handshake, state LOAD, w_ready=1, next weight written to addr 0.
5. w_valid gaps (weights on cycles 0,3,4,9) → exactly 4 preload strobes, contiguous addresses 0..3, no strobe in gap cycles.
6. rst asserted during RUN → next cycle all outputs 0, state LOAD, no res_valid; vector rejected until 4 new weights are loaded.
